// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver.
// IF stage: a 2-bit bimodal BHT and a direct-mapped BTB look up the fetch PC.
// EX stage: branches are resolved, mispredictions are detected, and a one-cycle
// registered redirect is issued to fetch. Saturating counters track branch and
// mispredict totals.
module branch_predict_unit #(
   parameter int XLEN    = 32,
   parameter int CTRL_W  = 22,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16,
   parameter int BIT_UBR = 7,
   parameter int BIT_RET = 4,
   parameter int BIT_BGT = 3,
   parameter int BIT_BEQ = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   IF_pc,
   output logic              IF_predTaken,
   output logic [XLEN-1:0]   IF_predTarget,
   input  logic              EX_valid,
   input  logic [XLEN-1:0]   EX_pc,
   input  logic              EX_predTaken,
   input  logic [XLEN-1:0]   EX_predTarget,
   input  logic [XLEN-1:0]   EX_branchTarget,
   input  logic [XLEN-1:0]   Operand_EX_A,
   input  logic [1:0]        flags,
   input  logic [CTRL_W-1:0] Input_EX_controlBus,
   output logic [XLEN-1:0]   EX_branchPC,
   output logic              EX_is_Branch_Taken,
   output logic              EX_redirect,
   output logic [XLEN-1:0]   EX_redirectPC,
   output logic [CNT_W-1:0]  stat_branches,
   output logic [CNT_W-1:0]  stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [1:0]        bht       [ENTRIES];
   logic [ENTRIES-1:0] btbValid;
   logic [TAG_W-1:0]  btbTag    [ENTRIES];
   logic [XLEN-1:0]   btbTarget [ENTRIES];

   logic [IDX_W-1:0]  ifIdx;
   logic [TAG_W-1:0]  ifTag;
   logic              ifHit;
   logic [IDX_W-1:0]  exIdx;
   logic [TAG_W-1:0]  exTag;
   logic              isBeq, isBgt, isUbr, isRet;
   logic              isBr, taken, brMispred, nbMispred, mispred;
   logic              unusedBits;

   assign unusedBits = &{1'b0, IF_pc[1:0], Input_EX_controlBus};

   // IF lookup: the target is only driven on a BTB tag hit
   always_comb begin
      ifIdx         = IF_pc[IDX_W+1:2];
      ifTag         = IF_pc[XLEN-1:IDX_W+2];
      ifHit         = btbValid[ifIdx] && (btbTag[ifIdx] == ifTag);
      IF_predTaken  = ifHit && bht[ifIdx][1];
      IF_predTarget = ifHit ? btbTarget[ifIdx] : '0;
   end

   // EX resolve and mispredict detection; ret is an always-taken jump
   always_comb begin
      exIdx              = EX_pc[IDX_W+1:2];
      exTag              = EX_pc[XLEN-1:IDX_W+2];
      isBeq              = Input_EX_controlBus[BIT_BEQ];
      isBgt              = Input_EX_controlBus[BIT_BGT];
      isUbr              = Input_EX_controlBus[BIT_UBR];
      isRet              = Input_EX_controlBus[BIT_RET];
      EX_branchPC        = isRet ? Operand_EX_A : EX_branchTarget;
      taken              = EX_valid && ((isBeq && flags[0]) || (isBgt && flags[1]) ||
                                        isUbr || isRet);
      isBr               = EX_valid && (isBeq || isBgt || isUbr || isRet);
      EX_is_Branch_Taken = taken;
      brMispred          = isBr && ((taken != EX_predTaken) ||
                                    (taken && (EX_predTarget != EX_branchPC)));
      nbMispred          = EX_valid && !isBr && EX_predTaken;
      mispred            = brMispred || nbMispred;
   end

   // BHT counters and BTB valid bits; a bogus prediction on a non-branch evicts the entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
         btbValid <= '0;
      end else if (isBr) begin
         if (taken) begin
            if (bht[exIdx] != 2'b11) bht[exIdx] <= bht[exIdx] + 2'b01;
            btbValid[exIdx] <= 1'b1;
         end else if (bht[exIdx] != 2'b00) begin
            bht[exIdx] <= bht[exIdx] - 2'b01;
         end
      end else if (nbMispred) begin
         btbValid[exIdx] <= 1'b0;
      end
   end

   // BTB tag/target payload, only meaningful under btbValid so not reset
   always_ff @(posedge clk) begin
      if (rst_n && isBr && taken) begin
         btbTag[exIdx]    <= exTag;
         btbTarget[exIdx] <= EX_branchPC;
      end
   end

   // One-cycle redirect pulse; the PC register holds between pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         EX_redirect   <= 1'b0;
         EX_redirectPC <= '0;
      end else begin
         EX_redirect <= mispred;
         if (mispred) EX_redirectPC <= taken ? EX_branchPC : EX_pc + XLEN'(4);
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (isBr && (stat_branches != '1))     stat_branches    <= stat_branches + CNT_W'(1);
         if (mispred && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
   end

endmodule
